// File: rtl/fpu_shared_arb.sv
// -----------------------------------------------------------------------------
// fpu_shared_arb
//
// Shares one fpu_core between NB_REQ requesters. Each cycle at most one request
// is granted. The grant is combinational, so the winner's operands go to the
// core in the same cycle and the core registers them. A LATENCY-deep tag pipe
// remembers who issued each op, so each result and flag set is steered back to
// the requester that issued it. Halt_SI stops new grants and lets in-flight ops
// drain, which gives a clean handshake for power-down.
//
// Parameters
//   NB_REQ   number of requesters (2..8)
//   LATENCY  cycles from FPU_Enable_SO to FPU_Valid_SI (fpu_core = 1)
//   FAIR_RR  1 = round-robin, 0 = fixed priority (lowest index wins)
//   C_OP / C_CMD / C_RM  operand, command and rounding-mode widths of the core
//
// Ports
//   Clk_CI, Rst_RBI            clock, asynchronous active-low reset
//   Req_SI / Gnt_SO            per-requester request and one-hot grant
//   Operand_a_DI, Operand_b_DI per-requester operands (flattened, requester 0 in LSBs)
//   OP_SI, RM_SI               per-requester command and rounding mode (flattened)
//   RValid_SO                  one-hot result valid
//   Result_DO, Flags_DO        result and {OF,UF,Zero,IX,IV,Inf}, broadcast
//   FPU_*_SO / FPU_*_DO        issue side, wired to the core inputs
//   FPU_Result_DI, FPU_Valid_SI, FPU_Flags_DI   return side from the core
//   Halt_SI                    stop granting, drain in-flight ops
//   Idle_SO                    high in IDLE and HALTED
//   Err_SO                     sticky: core valid disagreed with the tag pipe
//
// Optional build macro FPU_SHARED_ARB_FLAG_ACC_EN adds Flag_clr_SI and
// Flag_acc_DO: a sticky per-requester flag accumulator (fflags equivalent).
// -----------------------------------------------------------------------------
module fpu_shared_arb #(
   parameter int NB_REQ  = 4,
   parameter int LATENCY = 1,
   parameter int FAIR_RR = 1,
   parameter int C_OP    = 32,
   parameter int C_CMD   = 4,
   parameter int C_RM    = 2
) (
   input  logic                     Clk_CI,
   input  logic                     Rst_RBI,
   input  logic [NB_REQ-1:0]        Req_SI,
   output logic [NB_REQ-1:0]        Gnt_SO,
   input  logic [NB_REQ*C_OP-1:0]   Operand_a_DI,
   input  logic [NB_REQ*C_OP-1:0]   Operand_b_DI,
   input  logic [NB_REQ*C_CMD-1:0]  OP_SI,
   input  logic [NB_REQ*C_RM-1:0]   RM_SI,
   output logic [NB_REQ-1:0]        RValid_SO,
   output logic [C_OP-1:0]          Result_DO,
   output logic [5:0]               Flags_DO,
   output logic                     FPU_Enable_SO,
   output logic [C_OP-1:0]          FPU_Operand_a_DO,
   output logic [C_OP-1:0]          FPU_Operand_b_DO,
   output logic [C_CMD-1:0]         FPU_OP_SO,
   output logic [C_RM-1:0]          FPU_RM_SO,
   input  logic [C_OP-1:0]          FPU_Result_DI,
   input  logic                     FPU_Valid_SI,
   input  logic [5:0]               FPU_Flags_DI,
   input  logic                     Halt_SI,
   output logic                     Idle_SO,
`ifdef FPU_SHARED_ARB_FLAG_ACC_EN
   input  logic [NB_REQ-1:0]        Flag_clr_SI,
   output logic [NB_REQ*6-1:0]      Flag_acc_DO,
`endif
   output logic                     Err_SO
);

   localparam int IDX_W = (NB_REQ > 1) ? $clog2(NB_REQ) : 1;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DRAIN,
      HALTED
   } state_e;

   state_e             state, state_next;
   logic               grant_en;
   logic               any_gnt;
   logic [IDX_W-1:0]   win_id;
   logic [IDX_W-1:0]   rr_ptr;
   logic [IDX_W-1:0]   search_start;
   logic [IDX_W:0]     cand;

   logic [LATENCY-1:0] pipe_vld;
   logic [IDX_W-1:0]   pipe_id [LATENCY];
   logic               out_vld;
   logic [IDX_W-1:0]   out_id;
   logic               pipe_empty;

   // Grants only in IDLE/BUSY. Halt_SI is used combinationally so a request
   // arriving together with Halt_SI is never granted.
   assign grant_en = ((state == IDLE) || (state == BUSY)) && !Halt_SI;
   assign Idle_SO  = (state == IDLE) || (state == HALTED);

   // ---------------------------------------------------------------------------
   // Arbiter. Fixed priority is the same search started at index 0.
   // ---------------------------------------------------------------------------
   assign search_start = (FAIR_RR != 0) ? rr_ptr : '0;

   // NOTE: every signal written in an always_comb gets a default first, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      any_gnt = 1'b0;
      win_id  = '0;
      cand    = '0;
      Gnt_SO  = '0;
      for (int k = 0; k < NB_REQ; k++) begin
         // Candidate index wraps NB_REQ-1 -> 0; the extra bit holds the carry.
         cand = {1'b0, search_start} + (IDX_W+1)'(k);
         if (cand >= (IDX_W+1)'(NB_REQ)) cand = cand - (IDX_W+1)'(NB_REQ);
         if (!any_gnt && grant_en && Req_SI[cand[IDX_W-1:0]]) begin
            any_gnt = 1'b1;
            win_id  = cand[IDX_W-1:0];
         end
      end
      Gnt_SO[win_id] = any_gnt;
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge value of its neighbours.
   always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
      if (!Rst_RBI) begin
         rr_ptr <= '0;
      end else if (any_gnt) begin
         rr_ptr <= (win_id == IDX_W'(NB_REQ-1)) ? '0 : win_id + IDX_W'(1);
      end
   end

   // ---------------------------------------------------------------------------
   // Issue: winner's data to the core, zero-gated when nothing is granted so the
   // core's input flops do not toggle.
   // ---------------------------------------------------------------------------
   always_comb begin
      FPU_Enable_SO    = any_gnt;
      FPU_Operand_a_DO = '0;
      FPU_Operand_b_DO = '0;
      FPU_OP_SO        = '0;
      FPU_RM_SO        = '0;
      for (int i = 0; i < NB_REQ; i++) begin
         if (Gnt_SO[i]) begin
            FPU_Operand_a_DO = Operand_a_DI[i*C_OP  +: C_OP];
            FPU_Operand_b_DO = Operand_b_DI[i*C_OP  +: C_OP];
            FPU_OP_SO        = OP_SI[i*C_CMD +: C_CMD];
            FPU_RM_SO        = RM_SI[i*C_RM  +: C_RM];
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Tag pipe: shifts every cycle, stage 0 takes {grant, winner}.
   // ---------------------------------------------------------------------------
   // NOTE: the id stages are reset along with the valid bits; the pipe is tiny
   // and a cleared pipe keeps the return side deterministic after reset.
   always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
      if (!Rst_RBI) begin
         pipe_vld <= '0;
         for (int s = 0; s < LATENCY; s++) pipe_id[s] <= '0;
      end else begin
         pipe_vld[0] <= any_gnt;
         pipe_id[0]  <= win_id;
         for (int s = 1; s < LATENCY; s++) begin
            pipe_vld[s] <= pipe_vld[s-1];
            pipe_id[s]  <= pipe_id[s-1];
         end
      end
   end

   assign out_vld    = pipe_vld[LATENCY-1];
   assign out_id     = pipe_id[LATENCY-1];
   assign pipe_empty = (pipe_vld == '0);

   // Results follow the tag, never FPU_Valid_SI; a disagreement only sets Err_SO.
   always_comb begin
      RValid_SO = '0;
      for (int i = 0; i < NB_REQ; i++) begin
         RValid_SO[i] = out_vld && (out_id == IDX_W'(i));
      end
   end

   assign Result_DO = out_vld ? FPU_Result_DI : '0;
   assign Flags_DO  = out_vld ? FPU_Flags_DI  : '0;

   always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
      if (!Rst_RBI) begin
         Err_SO <= 1'b0;
      end else if (FPU_Valid_SI != out_vld) begin
         Err_SO <= 1'b1;
      end
   end

   // ---------------------------------------------------------------------------
   // Control FSM
   // ---------------------------------------------------------------------------
   always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
      if (!Rst_RBI) state <= IDLE;
      else          state <= state_next;
   end

   always_comb begin
      state_next = state;
      unique case (state)
         IDLE: begin
            if (Halt_SI)      state_next = HALTED;
            else if (any_gnt) state_next = BUSY;
         end
         BUSY: begin
            if (Halt_SI)                     state_next = DRAIN;
            else if (pipe_empty && !any_gnt) state_next = IDLE;
         end
         DRAIN: begin
            if (pipe_empty) state_next = HALTED;
         end
         HALTED: begin
            if (!Halt_SI) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

`ifdef FPU_SHARED_ARB_FLAG_ACC_EN
   // ---------------------------------------------------------------------------
   // Per-requester sticky flag accumulators. A clear coinciding with a result
   // for the same requester keeps the new flags.
   // ---------------------------------------------------------------------------
   logic [5:0] flag_acc [NB_REQ];

   always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
      if (!Rst_RBI) begin
         for (int i = 0; i < NB_REQ; i++) flag_acc[i] <= '0;
      end else begin
         for (int i = 0; i < NB_REQ; i++) begin
            if (RValid_SO[i])        flag_acc[i] <= Flag_clr_SI[i] ? Flags_DO : (flag_acc[i] | Flags_DO);
            else if (Flag_clr_SI[i]) flag_acc[i] <= '0;
         end
      end
   end

   always_comb begin
      Flag_acc_DO = '0;
      for (int i = 0; i < NB_REQ; i++) Flag_acc_DO[i*6 +: 6] = flag_acc[i];
   end
`endif

endmodule

// File: doc/fpu_shared_arb.md
Name: fpu_shared_arb

Overview:
- Shares one fpu_core instance between NB_REQ requesters, e.g. cluster cores.
- Grants one request per cycle: round-robin by default, fixed priority optional via parameter.
- Drives the core's input ports directly; the core registers them.
- Tracks in-flight ops with a LATENCY-deep tag pipe and routes each result and flag set back to the issuing requester.
- Provides a halt/drain handshake for power-down.

Parameters:
NB_REQ, 4, number of requesters (2..8)
LATENCY, 1, cycles from FPU_Enable_SO high to FPU_Valid_SI high (fpu_core = 1)
FAIR_RR, 1, 1 = round-robin arbitration, 0 = fixed priority (lowest index wins)

Ports:
Clk_CI  in  1  clock
Rst_RBI  in  1  async active-low reset
Req_SI  in  NB_REQ  request per requester
Gnt_SO  out  NB_REQ  one-hot grant; operands sampled in the cycle Req&Gnt
Operand_a_DI  in  NB_REQ x C_OP  operand a per requester
Operand_b_DI  in  NB_REQ x C_OP  operand b per requester
OP_SI  in  NB_REQ x C_CMD  command per requester
RM_SI  in  NB_REQ x C_RM  rounding mode per requester
RValid_SO  out  NB_REQ  one-hot result valid
Result_DO  out  C_OP  result, broadcast to all requesters
Flags_DO  out  6  {OF,UF,Zero,IX,IV,Inf}, broadcast
FPU_Enable_SO  out  1  to core Enable_SI
FPU_Operand_a_DO  out  C_OP  to core
FPU_Operand_b_DO  out  C_OP  to core
FPU_OP_SO  out  C_CMD  to core
FPU_RM_SO  out  C_RM  to core
FPU_Result_DI  in  C_OP  from core Result_DO
FPU_Valid_SI  in  1  from core Valid_SO
FPU_Flags_DI  in  6  from core {OF,UF,Zero,IX,IV,Inf}
Halt_SI  in  1  stop granting, drain in-flight ops
Idle_SO  out  1  no op in flight and not granting
Err_SO  out  1  sticky: FPU_Valid_SI disagrees with the tag pipe

Behaviour:
- Reset values:
  - Gnt_SO, RValid_SO, FPU_Enable_SO, Err_SO = 0.
  - Idle_SO = 1.
  - Tag pipe cleared; RR pointer = 0; FSM = IDLE.
  - Core data outputs = 0 (zero-gated).
- Grant path is combinational in the same cycle.
  - At most one Gnt_SO bit per cycle; a Gnt bit only goes high together with its Req.
  - Requester holds Req and its data stable until granted.
- Issue:
  - On a grant, winner's operands/OP/RM go to FPU_* and FPU_Enable_SO = 1.
  - Otherwise FPU_Enable_SO = 0 and FPU_* data = 0 (power gating, same style as the core's per-unit gating).
- Round-robin (FAIR_RR = 1):
  - Search starts at the RR pointer and wraps NB_REQ-1 -> 0.
  - After a grant to index i, pointer = (i+1) mod NB_REQ.
  - Pointer holds when nothing is granted.
- Tag pipe: LATENCY stages of {valid, id[$clog2(NB_REQ)]}, shifted every cycle. Stage 0 is loaded with {grant, winner id}.
- At pipe output with valid = 1:
  - RValid_SO[id] = 1 for exactly one cycle.
  - Result_DO = FPU_Result_DI; Flags_DO = FPU_Flags_DI.
  - No backpressure: the requester must accept the result.
- Throughput is one op per cycle. Results return in issue order, exactly LATENCY cycles after the grant.
- Err_SO is set when FPU_Valid_SI != pipe-output valid. It is cleared only by reset. Results still follow the tag, not FPU_Valid_SI.
- FSM:
  - IDLE: pipe empty. A grant goes to BUSY. Halt_SI goes to HALTED.
  - BUSY: grants allowed. Halt_SI goes to DRAIN. When the pipe is empty and there is no grant, go to IDLE.
  - DRAIN: no grants. When the pipe is empty, go to HALTED.
  - HALTED: no grants; Idle_SO = 1. Halt_SI = 0 goes to IDLE.
- Simultaneous events:
  - If Halt_SI rises in the same cycle as a Req, that request is not granted (Halt is checked combinationally).
  - A result return and a new grant in the same cycle are both served.
- Reset mid-operation discards every in-flight op; no RValid is produced for it.
- Idle_SO = 1 in IDLE and HALTED, otherwise 0.

Optional Feature:
FPU_SHARED_ARB_FLAG_ACC_EN:
- When defined, adds ports Flag_clr_SI [NB_REQ] (in) and Flag_acc_DO [NB_REQ x 6] (out).
- Each requester has a sticky per-requester accumulator, the fflags equivalent. It ORs in Flags_DO on each of that requester's RValid.
- Flag_clr_SI[i] clears accumulator i. If a clear and an RValid for the same requester coincide, the new flags win: acc = Flags_DO.
- Reset value 0.
- When not defined, the ports and registers are absent.

Test Plan:
- Single op: req0 ADD 0x3F800000 + 0x40000000 -> Gnt_SO = 0001 same cycle; one cycle later RValid_SO = 0001, Result_DO = 0x40400000, Flags_DO = 0.
- Contention: all four Req held, each MUL 0x40000000 * 0x40400000 -> grants 0,1,2,3,0 on consecutive cycles; each RValid = 0x40C00000 and matches the issuer one cycle after its grant.
- Fixed priority (FAIR_RR = 0): Req = 1010 held -> Gnt stays 0010 until Req1 drops; Req3 is granted the next cycle.
- Halt: grant issued, Halt_SI = 1 next cycle -> no new grants; the pending RValid is delivered; FSM reaches HALTED; Idle_SO = 1; releasing Halt restores grants.
- Async reset asserted one cycle after a grant -> no RValid; Idle_SO = 1; RR pointer = 0; Err_SO = 0.
- Flag accumulation (macro defined): req2 does 0x00000000 / invalid op giving IV, then a valid ADD -> Flag_acc_DO[2] keeps IV; Flag_clr_SI[2] clears it to 0.
